// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg: shared definitions for the 2x2 systolic TPU control path.
//   - seq_state_e : mmu_sequencer FSM encoding
//   - N_LOAD / N_COMPUTE / N_OUT / CNT_W : job geometry
//   - WEIGHT_BASE / INPUT_BASE : operand memory layout (weights, then inputs)
// -----------------------------------------------------------------------------
package tpu_pkg;
  localparam int N_LOAD      = 8;   // operand bytes per job
  localparam int N_COMPUTE   = 5;   // feeder cycles per job
  localparam int N_OUT       = 8;   // result bytes per job (4 x 16b, low first)
  localparam int CNT_W       = 3;   // width of every sequencer counter
  localparam int WEIGHT_BASE = 0;
  localparam int INPUT_BASE  = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CLEAR   = 3'd2,
    COMPUTE = 3'd3,
    OUTPUT  = 3'd4
  } seq_state_e;
endpackage

// File: rtl/mmu_sequencer_if.sv
// -----------------------------------------------------------------------------
// mmu_sequencer_if: host strobes in, memory / PE / feeder / host controls out.
//   master : host side (drives load_strb, out_ack, abort)
//   slave  : sequencer side (drives write enable/address, PE clear, feeder
//            enable/cycle, result select/valid, busy, done)
// -----------------------------------------------------------------------------
interface mmu_sequencer_if import tpu_pkg::*; ();
  logic load_strb;
  logic out_ack;
  logic abort;
  logic mem_write_en;
  cnt_t mem_addr;
  logic clear_pe;
  logic mmu_en;
  cnt_t mmu_cycle;
  cnt_t out_sel;
  logic out_valid;
  logic busy;
  logic done;

  modport master (
    output load_strb, out_ack, abort,
    input  mem_write_en, mem_addr, clear_pe, mmu_en, mmu_cycle,
           out_sel, out_valid, busy, done
  );

  modport slave (
    input  load_strb, out_ack, abort,
    output mem_write_en, mem_addr, clear_pe, mmu_en, mmu_cycle,
           out_sel, out_valid, busy, done
  );
endinterface

// File: rtl/mmu_sequencer_counter.sv
// -----------------------------------------------------------------------------
// seq_counter: W-bit up-counter that wraps to 0 after reaching TC.
//   clk, rst_n : clock, synchronous active-low reset
//   clr_i      : synchronous clear (wins over en_i)
//   en_i       : count enable
//   cnt_o      : current count
//   tc_o       : count equals TC (the enabled step from here wraps to 0)
// -----------------------------------------------------------------------------
module seq_counter #(
  parameter int W  = 3,
  parameter int TC = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == W'(TC));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tc_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mmu_sequencer.sv
// -----------------------------------------------------------------------------
// mmu_sequencer: job controller for the 2x2 systolic datapath.
//   Loads N_LOAD operand bytes, clears the PEs for one cycle, runs the feeder
//   for N_COMPUTE cycles, then steps N_OUT result bytes out under out_ack and
//   raises a sticky done.
//   clk, rst_n : clock, synchronous active-low reset (mid-job reset == abort)
//   bus        : mmu_sequencer_if.slave (host strobes in, controls out)
// -----------------------------------------------------------------------------
module mmu_sequencer import tpu_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  mmu_sequencer_if.slave   bus
);
  seq_state_e state_q, state_d;
  logic       done_q, done_d;
  cnt_t       load_cnt, cyc_cnt, out_cnt;
  logic       load_tc, cyc_tc, out_tc;
  logic       wr_en, ack_en;

  // Write path is combinational so the address lines up with ui_in in the
  // same cycle as the strobe; abort suppresses the write.
  assign wr_en  = bus.load_strb & ~bus.abort &
                  ((state_q == IDLE) | (state_q == LOAD));
  assign ack_en = bus.out_ack & ~bus.abort & (state_q == OUTPUT);

  // Counters wrap to 0 on their terminal step, so every phase starts at 0
  // without an explicit clear; abort restores them to 0 directly.
  seq_counter #(.W(CNT_W), .TC(N_LOAD-1)) u_load (
    .clk(clk), .rst_n(rst_n), .clr_i(bus.abort), .en_i(wr_en),
    .cnt_o(load_cnt), .tc_o(load_tc));

  seq_counter #(.W(CNT_W), .TC(N_COMPUTE-1)) u_cyc (
    .clk(clk), .rst_n(rst_n), .clr_i(bus.abort), .en_i(state_q == COMPUTE),
    .cnt_o(cyc_cnt), .tc_o(cyc_tc));

  seq_counter #(.W(CNT_W), .TC(N_OUT-1)) u_out (
    .clk(clk), .rst_n(rst_n), .clr_i(bus.abort), .en_i(ack_en),
    .cnt_o(out_cnt), .tc_o(out_tc));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    if (bus.abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.load_strb) begin
          state_d = LOAD;
          done_d  = 1'b0;   // first byte of a new job retires the old done
        end
        LOAD:    if (bus.load_strb && load_tc) state_d = CLEAR;
        CLEAR:   state_d = COMPUTE;
        COMPUTE: if (cyc_tc) state_d = OUTPUT;
        OUTPUT: if (bus.out_ack && out_tc) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Everything except the write path decodes straight from registers.
  assign bus.mem_write_en = wr_en;
  assign bus.mem_addr     = load_cnt;
  assign bus.clear_pe     = (state_q == CLEAR);
  assign bus.mmu_en       = (state_q == COMPUTE);
  assign bus.mmu_cycle    = cyc_cnt;
  assign bus.out_sel      = out_cnt;
  assign bus.out_valid    = (state_q == OUTPUT);
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
endmodule

// File: tb/tb_mmu_sequencer.sv
// Self-checking bench for mmu_sequencer: a table of directed vectors, a few
// hand-written sequences and a randomized run against a job-timeline model.
module tb_mmu_sequencer;
  import tpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mmu_sequencer_if bus ();
  mmu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct packed {
    logic       we;
    logic [2:0] addr;
    logic       clr;
    logic       en;
    logic [2:0] cyc;
    logic [2:0] sel;
    logic       ov;
    logic       busy;
    logic       done;
  } outs_t;

  typedef struct {
    logic  s, a, ab, rn;
    outs_t e;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Job timeline model: bytes loaded so far, cycles elapsed since the final
  // byte, results acknowledged, and the sticky done flag.
  int m_loaded, m_t, m_acks;
  bit m_done;

  function automatic outs_t mk(logic we, logic [2:0] addr, logic clr, logic en,
                               logic [2:0] cy, logic [2:0] sel, logic ov,
                               logic busy, logic dn);
    outs_t o;
    o.we = we; o.addr = addr; o.clr = clr; o.en = en; o.cyc = cy;
    o.sel = sel; o.ov = ov; o.busy = busy; o.done = dn;
    return o;
  endfunction

  function automatic outs_t dut_out();
    return mk(bus.mem_write_en, bus.mem_addr, bus.clear_pe, bus.mmu_en,
              bus.mmu_cycle, bus.out_sel, bus.out_valid, bus.busy, bus.done);
  endfunction

  function automatic outs_t model_out(logic s, logic ab);
    outs_t o = '0;
    if (m_loaded < N_LOAD) begin
      o.we   = s & ~ab;
      o.addr = 3'(m_loaded);
    end else begin
      // t=0: PE clear; t=1..N_COMPUTE: feeder; afterwards: results out.
      o.clr = (m_t == 0);
      o.en  = (m_t >= 1) && (m_t <= N_COMPUTE);
      if (o.en) o.cyc = 3'(m_t - 1);
      o.ov  = (m_t > N_COMPUTE);
      o.sel = 3'(m_acks);
    end
    o.busy = (m_loaded > 0);
    o.done = m_done;
    return o;
  endfunction

  task automatic model_step(input logic s, input logic a, input logic ab, input logic rn);
    if (!rn || ab) begin
      m_loaded = 0; m_t = 0; m_acks = 0; m_done = 0;
    end else if (m_loaded < N_LOAD) begin
      if (s) begin
        if (m_loaded == 0) m_done = 0;
        m_loaded++;
        m_t = 0;
      end
    end else if (m_t <= N_COMPUTE) begin
      m_t++;
    end else if (a) begin
      m_acks++;
      if (m_acks == N_OUT) begin
        m_loaded = 0; m_acks = 0; m_done = 1;
      end
    end
  endtask

  task automatic chk(input string nm, input outs_t act, input outs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got we=%b addr=%0d clr=%b en=%b cyc=%0d sel=%0d ov=%b busy=%b done=%b, expected we=%b addr=%0d clr=%b en=%b cyc=%0d sel=%0d ov=%b busy=%b done=%b",
               nm, act.we, act.addr, act.clr, act.en, act.cyc, act.sel, act.ov, act.busy, act.done,
               exp.we, exp.addr, exp.clr, exp.en, exp.cyc, exp.sel, exp.ov, exp.busy, exp.done);
    end
  endtask

  // One clock: drive at posedge+1, check at negedge against the model,
  // advance the model at the next posedge.
  task automatic cyc(input logic s, input logic a, input logic ab, input logic rn,
                     input string nm, input bit glitch);
    outs_t e;
    bus.load_strb = s; bus.out_ack = a; bus.abort = ab; rst_n = rn;
    e = model_out(s, ab);
    if (glitch) begin
      #2 rst_n = 1'b0;
      #1 rst_n = 1'b1;
    end
    @(negedge clk);
    chk(nm, dut_out(), e);
    @(posedge clk);
    model_step(s, a, ab, rn);
    #1;
  endtask

  task automatic apply_row(input vec_t v, input int idx);
    bus.load_strb = v.s; bus.out_ack = v.a; bus.abort = v.ab; rst_n = v.rn;
    @(negedge clk);
    chk($sformatf("tbl[%0d]", idx), dut_out(), v.e);
    @(posedge clk);
    model_step(v.s, v.a, v.ab, v.rn);
    #1;
  endtask

  function automatic void row(logic s, logic a, logic ab, logic rn, outs_t e);
    vec_t v;
    v.s = s; v.a = a; v.ab = ab; v.rn = rn; v.e = e;
    tbl.push_back(v);
  endfunction

  task automatic load_n(input int n, input int gap, input string nm);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, nm, 1'b0);
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, 1'b1, nm, 1'b0);
    end
  endtask

  initial begin
    outs_t z;
    z = '0;

    // Directed table: one full job with ignored strobes/acks sprinkled in,
    // then a new job that is aborted together with a strobe.
    row(0, 0, 0, 1, z);                                             // reset state
    row(0, 1, 0, 1, z);                                             // ack in IDLE
    for (int i = 0; i < 8; i++)
      row(1, logic'(i == 3), 0, 1, mk(1, 3'(i), 0, 0, 0, 0, 0, logic'(i > 0), 0));
    row(1, 0, 0, 1, mk(0, 0, 1, 0, 0, 0, 0, 1, 0));                 // CLEAR
    for (int k = 0; k < 5; k++)
      row(logic'(k == 1), logic'(k == 2), 0, 1, mk(0, 0, 0, 1, 3'(k), 0, 0, 1, 0));
    row(1, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1, 1, 0));                 // first out_valid
    for (int j = 0; j < 8; j++)
      row(0, 1, 0, 1, mk(0, 0, 0, 0, 0, 3'(j), 1, 1, 0));
    row(0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));                 // done, idle
    row(0, 1, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));                 // ack ignored
    row(1, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 0, 0, 1));                 // next job byte 0
    row(0, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 0, 1, 0));                 // done cleared
    row(1, 0, 1, 1, mk(0, 1, 0, 0, 0, 0, 0, 1, 0));                 // abort beats strobe
    row(0, 0, 0, 1, z);

    bus.load_strb = 0; bus.out_ack = 0; bus.abort = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    m_loaded = 0; m_t = 0; m_acks = 0; m_done = 0;

    foreach (tbl[i]) apply_row(tbl[i], i);

    // Gapped loads, ack held high from CLEAR onward, then back-to-back jobs.
    load_n(8, 2, "gap_load");
    for (int i = 0; i < 6 + 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, "ack_held", 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, "done_sticky", 1'b0);
    for (int job = 0; job < 2; job++) begin
      load_n(8, 0, "b2b_load");
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, "b2b_run", 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, "b2b_out", 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "b2b_done", 1'b0);

    // Abort after five loads, then a clean job.
    load_n(5, 0, "ab_load");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, "abort_strb", 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "abort_idle", 1'b0);
    load_n(8, 0, "fresh_load");
    for (int i = 0; i < 6 + 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, "fresh_out", 1'b0);

    // Reset pulse in OUTPUT at out_sel=3, and a between-edge glitch.
    load_n(8, 0, "rst_load");
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, "rst_run", 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, "rst_ack", 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "rst_out3", 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "post_rst", 1'b0);
    load_n(3, 0, "glitch_load");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "glitch", 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, "post_glitch", 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, "glitch_abort", 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic s, a, ab, rn;
      s  = logic'($urandom_range(0, 2) == 0);
      a  = logic'($urandom_range(0, 1));
      ab = logic'($urandom_range(0, 99) == 0);
      rn = logic'($urandom_range(0, 299) != 0);
      cyc(s, a, ab, rn, "rand", 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
